// File: rtl/output_process_spi.sv
// SPI transmit framer: prefix, command, optional length, data words
// from a show-ahead FIFO and optional checksum, shifted out MSB-first.
//
// Ports:
//   RX_CLK      bit clock, all logic on the rising edge
//   RST         asynchronous reset, active-low
//   START       one-cycle send request, honoured only while idle
//   CMD         command word; CMD[0] = length word, CMD[1] = checksum
//   LEN         number of 16-bit data words, latched with START
//   DATA_IN     head of the response FIFO (show-ahead)
//   DATA_EMPTY  response FIFO empty
//   DATA_REQ    one-cycle FIFO pop
//   TX_DATA     serial data, MSB first
//   TX_LOAD     high during bit 0 of every word
//   TX_STOP     one-cycle pulse after the last bit of a message
//   BUSY        message in progress
//   UNDERRUN    sticky FIFO-empty-on-fetch flag, cleared by next START
module output_process_spi #(
    parameter logic [15:0] PREFIX   = 16'h55AA,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic        RX_CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] CMD,
    input  logic [7:0]  LEN,
    input  logic [15:0] DATA_IN,
    input  logic        DATA_EMPTY,
    output logic        DATA_REQ,
    output logic        TX_DATA,
    output logic        TX_LOAD,
    output logic        TX_STOP,
    output logic        BUSY,
    output logic        UNDERRUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    state_t      tail;
    state_t      after_hdr;
    logic [15:0] shreg;
    logic [15:0] shreg_nxt;
    logic [3:0]  bit_cnt;
    logic [3:0]  bit_cnt_nxt;
    logic [7:0]  word_cnt;
    logic [7:0]  word_cnt_nxt;
    logic [15:0] csum;
    logic [15:0] csum_nxt;
    logic [15:0] cmd_q;
    logic [7:0]  len_q;
    logic        underrun_nxt;
    logic [15:0] fetch_word;
    logic        in_word;
    logic        accept;

    assign accept  = (state == S_IDLE) && START;
    assign in_word = (state == S_PREFIX) || (state == S_CMD) ||
                     (state == S_LEN)    || (state == S_DATA) ||
                     (state == S_CHK);

    // Where the message goes after its mandatory/optional header words.
    assign tail      = cmd_q[1] ? S_CHK : S_STOP;
    assign after_hdr = (len_q != 8'd0) ? S_DATA : tail;

    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            shreg    <= 16'h0000;
            bit_cnt  <= 4'd0;
            word_cnt <= 8'd0;
            csum     <= 16'h0000;
            cmd_q    <= 16'h0000;
            len_q    <= 8'd0;
            UNDERRUN <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word_cnt <= word_cnt_nxt;
            csum     <= csum_nxt;
            UNDERRUN <= underrun_nxt;
            if (accept) begin
                cmd_q <= CMD;
                len_q <= LEN;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        csum_nxt     = csum;
        underrun_nxt = UNDERRUN;
        fetch_word   = 16'h0000;
        DATA_REQ     = 1'b0;
        BUSY         = (state != S_IDLE);
        TX_STOP      = (state == S_STOP);
        TX_LOAD      = in_word && (bit_cnt == 4'd0);
        TX_DATA      = in_word ? shreg[15] : IDLE_BIT;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt    = S_PREFIX;
                    shreg_nxt    = PREFIX;
                    bit_cnt_nxt  = 4'd15;
                    word_cnt_nxt = 8'd0;
                    csum_nxt     = 16'h0000;
                    underrun_nxt = 1'b0;
                end
            end
            S_STOP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                if (bit_cnt != 4'd0) begin
                    shreg_nxt   = {shreg[14:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - 4'd1;
                end else begin
                    // Last bit of this word: pick the next word and load
                    // it now so words run back-to-back.
                    bit_cnt_nxt = 4'd15;
                    unique case (state)
                        S_PREFIX: state_nxt = S_CMD;
                        S_CMD:    state_nxt = cmd_q[0] ? S_LEN : after_hdr;
                        S_LEN:    state_nxt = after_hdr;
                        S_DATA:   state_nxt = (word_cnt != len_q) ? S_DATA : tail;
                        default:  state_nxt = S_STOP;
                    endcase

                    case (state_nxt)
                        S_CMD: begin
                            shreg_nxt = cmd_q;
                            csum_nxt  = csum + cmd_q;
                        end
                        S_LEN: begin
                            shreg_nxt = {8'h00, len_q};
                            csum_nxt  = csum + {8'h00, len_q};
                        end
                        S_DATA: begin
                            // An empty FIFO is not popped; a zero word
                            // goes out and is still summed.
                            if (!DATA_EMPTY) begin
                                DATA_REQ   = 1'b1;
                                fetch_word = DATA_IN;
                            end else begin
                                underrun_nxt = 1'b1;
                            end
                            shreg_nxt    = fetch_word;
                            csum_nxt     = csum + fetch_word;
                            word_cnt_nxt = word_cnt + 8'd1;
                        end
                        S_CHK: begin
                            shreg_nxt = csum;
                        end
                        default: begin
                            shreg_nxt = 16'h0000;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_output_process_spi.sv
// Self-checking bench for output_process_spi: directed and random
// messages compared bit-by-bit against a word-list reference model.
module tb_output_process_spi;

    logic        RX_CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [15:0] CMD = 16'h0000;
    logic [7:0]  LEN = 8'd0;
    logic [15:0] DATA_IN = 16'hDEAD;
    logic        DATA_EMPTY = 1'b1;
    logic        DATA_REQ;
    logic        TX_DATA;
    logic        TX_LOAD;
    logic        TX_STOP;
    logic        BUSY;
    logic        UNDERRUN;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] fifo[$];
    logic [15:0] src[$];

    always #5 RX_CLK = ~RX_CLK;

    output_process_spi dut (
        .RX_CLK(RX_CLK),
        .RST(RST),
        .START(START),
        .CMD(CMD),
        .LEN(LEN),
        .DATA_IN(DATA_IN),
        .DATA_EMPTY(DATA_EMPTY),
        .DATA_REQ(DATA_REQ),
        .TX_DATA(TX_DATA),
        .TX_LOAD(TX_LOAD),
        .TX_STOP(TX_STOP),
        .BUSY(BUSY),
        .UNDERRUN(UNDERRUN)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        DATA_EMPTY = (fifo.size() == 0);
        DATA_IN    = (fifo.size() != 0) ? fifo[0] : 16'($urandom);
    endtask

    // Sends one message with FIFO contents taken from src. again>0
    // re-pulses START in that cycle, which must be ignored.
    task automatic run_msg(input logic [15:0] cmd, input logic [7:0] len,
                           input int again);
        logic [15:0] words[$];
        logic [15:0] sum;
        logic [15:0] w;
        logic [4:0]  exp_v;
        logic [4:0]  obs_v;
        logic        req;
        int          n;
        int          first;
        int          stop_c;
        int          i;
        int          b;
        int          k;

        n = src.size();
        words.push_back(16'h55AA);
        words.push_back(cmd);
        sum = cmd;
        if (cmd[0]) begin
            words.push_back({8'h00, len});
            sum = sum + {8'h00, len};
        end
        first = words.size();
        for (int j = 0; j < int'(len); j++) begin
            w = (j < n) ? src[j] : 16'h0000;
            words.push_back(w);
            sum = sum + w;
        end
        if (cmd[1]) words.push_back(sum);
        stop_c = 16 * words.size() + 1;

        @(negedge RX_CLK);
        START = 1'b1;
        CMD   = cmd;
        LEN   = len;
        fifo  = src;
        fifo_sync();
        @(posedge RX_CLK);
        #1;
        START = 1'b0;
        CMD   = 16'($urandom);
        LEN   = 8'($urandom);

        for (int c = 1; c <= stop_c + 2; c++) begin
            @(negedge RX_CLK);
            if (c <= stop_c - 1) begin
                i = (c - 1) / 16;
                b = 15 - ((c - 1) % 16);
                k = i + 1 - first;
                exp_v = {words[i][b], (b == 0), 1'b0, 1'b1,
                         (b == 0) && (k >= 0) && (k < int'(len)) && (k < n)};
            end else if (c == stop_c) begin
                exp_v = 5'b00110;
            end else begin
                exp_v = 5'b00000;
            end
            obs_v = {TX_DATA, TX_LOAD, TX_STOP, BUSY, DATA_REQ};
            check($sformatf("cyc%0d dat/ld/stp/bsy/req", c), 32'(obs_v), 32'(exp_v));
            if (c == 1)
                check("underrun_cleared", 32'(UNDERRUN), 32'd0);
            if (c == stop_c)
                check("underrun_end", 32'(UNDERRUN), 32'(int'(len) > n));
            req = DATA_REQ;
            if (c == again) begin
                START = 1'b1;
                CMD   = 16'($urandom);
                LEN   = 8'($urandom);
            end
            @(posedge RX_CLK);
            #1;
            START = 1'b0;
            if (req && fifo.size() != 0) begin
                void'(fifo.pop_front());
                fifo_sync();
            end
        end
    endtask

    initial begin
        logic [7:0] len;
        int         cnt;
        int         stop_c;

        #2;
        check("reset_outputs",
              32'({TX_DATA, TX_LOAD, TX_STOP, BUSY, DATA_REQ, UNDERRUN}), 32'd0);
        @(negedge RX_CLK);
        RST = 1'b1;

        src = '{16'h1234, 16'h0001};
        run_msg(16'h0003, 8'd2, 0);
        src = {};
        run_msg(16'hFF00, 8'd0, 0);
        src = '{16'hFFFF, 16'hFFFF};
        run_msg(16'h0002, 8'd2, 0);
        src = '{16'hABCD};
        run_msg(16'h0001, 8'd3, 0);
        src = '{16'h0F0F};
        run_msg(16'h0000, 8'd1, 20);
        src = '{16'h4321};
        run_msg(16'h0003, 8'd1, 81);

        for (int t = 0; t < 12; t++) begin
            len = 8'($urandom_range(0, 6));
            cnt = $urandom_range(0, int'(len) + 1);
            src = {};
            for (int j = 0; j < cnt; j++) src.push_back(16'($urandom));
            stop_c = 16 * (2 + int'(len) + 2) + 1;
            run_msg(16'($urandom), len, $urandom_range(0, 40));
        end

        src = {};
        for (int j = 0; j < 255; j++) src.push_back(16'($urandom));
        run_msg(16'h0003, 8'd255, 0);

        // Abort in the middle of the first data word (bit 7).
        @(negedge RX_CLK);
        START = 1'b1;
        CMD   = 16'h0001;
        LEN   = 8'd3;
        fifo  = '{16'h1111, 16'h2222, 16'h3333};
        fifo_sync();
        @(posedge RX_CLK);
        #1;
        START = 1'b0;
        repeat (56) @(posedge RX_CLK);
        #2;
        check("pre_abort_busy", 32'({TX_LOAD, TX_STOP, BUSY}), 32'b001);
        RST = 1'b0;
        #1;
        check("abort_outputs",
              32'({TX_DATA, TX_LOAD, TX_STOP, BUSY, DATA_REQ, UNDERRUN}), 32'd0);
        repeat (2) @(negedge RX_CLK);
        check("abort_held",
              32'({TX_DATA, TX_LOAD, TX_STOP, BUSY, DATA_REQ}), 32'd0);
        RST = 1'b1;
        src = '{16'hCAFE, 16'hBEEF};
        run_msg(16'h0003, 8'd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
